// File: rtl/tsc_pkg.sv
// Shared definitions for the traffic signal controller: phase encodings,
// default phase lengths and the direction flag used to resume after WALK.
package tsc_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        EW_GREEN  = 3'd2,
        EW_YELLOW = 3'd3,
        WALK      = 3'd4
    } tsc_state_e;

    localparam int DEF_GREEN_CYC  = 10;
    localparam int DEF_YELLOW_CYC = 3;
    localparam int DEF_WALK_CYC   = 6;
    localparam int DEF_CNT_W      = 8;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/tsc_phase_timer.sv
// Phase length counter: counts edges within the current phase and flags the
// final edge when the count reaches the phase's last index.
module tsc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tsc.sv
// Four-way traffic signal controller with an all-red pedestrian WALK phase
// inserted after a yellow whenever a crossing request is pending.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  NS_GREEN  | north/south go, east/west and walk red
//  NS_YELLOW | north/south clearing, may hand over to WALK
//  EW_GREEN  | east/west go, north/south and walk red
//  EW_YELLOW | east/west clearing, may hand over to WALK
//  WALK      | all vehicle heads red, pedestrian green
module tsc
    import tsc_pkg::*;
#(
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i,
    output logic NORTH_GREEN,
    output logic NORTH_YELLOW,
    output logic NORTH_RED,
    output logic EAST_GREEN,
    output logic EAST_YELLOW,
    output logic EAST_RED,
    output logic WALK_GREEN,
    output logic WALK_RED
);

    localparam logic [2:0] S_NS_GREEN  = NS_GREEN;
    localparam logic [2:0] S_NS_YELLOW = NS_YELLOW;
    localparam logic [2:0] S_EW_GREEN  = EW_GREEN;
    localparam logic [2:0] S_EW_YELLOW = EW_YELLOW;
    localparam logic [2:0] S_WALK      = WALK;

    localparam logic [CNT_W-1:0] LAST_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_WALK   = CNT_W'(WALK_CYC - 1);

    // Plain vector rather than the enum so spare encodings stay representable.
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             req;
    logic             next_dir;
    logic             next_dir_nxt;
    logic             enter_walk;
    logic             illegal;
    logic [CNT_W-1:0] phase_last;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    tsc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tc | illegal),
        .last  (phase_last),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_comb begin
        phase_last = '0;
        case (state)
            S_NS_GREEN,
            S_EW_GREEN:  phase_last = LAST_GREEN;
            S_NS_YELLOW,
            S_EW_YELLOW: phase_last = LAST_YELLOW;
            S_WALK:      phase_last = LAST_WALK;
            default:     phase_last = '0;
        endcase
    end

    // A press landing on the final yellow edge still counts, hence req | i.
    always_comb begin
        state_nxt    = state;
        next_dir_nxt = next_dir;
        enter_walk   = 1'b0;
        illegal      = 1'b0;
        case (state)
            S_NS_GREEN: begin
                if (tc) state_nxt = S_NS_YELLOW;
            end
            S_NS_YELLOW: begin
                if (tc) begin
                    if (req | i) begin
                        state_nxt    = S_WALK;
                        enter_walk   = 1'b1;
                        next_dir_nxt = DIR_EW;
                    end else begin
                        state_nxt = S_EW_GREEN;
                    end
                end
            end
            S_EW_GREEN: begin
                if (tc) state_nxt = S_EW_YELLOW;
            end
            S_EW_YELLOW: begin
                if (tc) begin
                    if (req | i) begin
                        state_nxt    = S_WALK;
                        enter_walk   = 1'b1;
                        next_dir_nxt = DIR_NS;
                    end else begin
                        state_nxt = S_NS_GREEN;
                    end
                end
            end
            S_WALK: begin
                if (tc) state_nxt = (next_dir == DIR_EW) ? S_EW_GREEN : S_NS_GREEN;
            end
            default: begin
                illegal   = 1'b1;
                state_nxt = S_NS_GREEN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_NS_GREEN;
            req      <= 1'b0;
            next_dir <= DIR_EW;
        end else begin
            state    <= state_nxt;
            next_dir <= next_dir_nxt;
            if (enter_walk) begin
                req <= 1'b0;
            end else if (i && state != S_WALK) begin
                req <= 1'b1;
            end
        end
    end

    always_comb begin
        NORTH_GREEN  = 1'b0;
        NORTH_YELLOW = 1'b0;
        NORTH_RED    = 1'b1;
        EAST_GREEN   = 1'b0;
        EAST_YELLOW  = 1'b0;
        EAST_RED     = 1'b1;
        WALK_GREEN   = 1'b0;
        WALK_RED     = 1'b1;
        case (state)
            S_NS_GREEN: begin
                NORTH_GREEN = 1'b1;
                NORTH_RED   = 1'b0;
            end
            S_NS_YELLOW: begin
                NORTH_YELLOW = 1'b1;
                NORTH_RED    = 1'b0;
            end
            S_EW_GREEN: begin
                EAST_GREEN = 1'b1;
                EAST_RED   = 1'b0;
            end
            S_EW_YELLOW: begin
                EAST_YELLOW = 1'b1;
                EAST_RED    = 1'b0;
            end
            S_WALK: begin
                WALK_GREEN = 1'b1;
                WALK_RED   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tsc.sv
// Bench for the traffic signal controller: scenario table with hand-derived
// lamp checkpoints plus a cycle-level reference model feeding a scoreboard.
module tb_tsc;

    localparam int GREEN_CYC  = 10;
    localparam int YELLOW_CYC = 3;
    localparam int WALK_CYC   = 6;

    // lamp vector order: {NG, NY, NR, EG, EY, ER, WG, WR}
    localparam logic [7:0] L_NSG  = 8'b1000_0101;
    localparam logic [7:0] L_NSY  = 8'b0100_0101;
    localparam logic [7:0] L_EWG  = 8'b0011_0001;
    localparam logic [7:0] L_EWY  = 8'b0010_1001;
    localparam logic [7:0] L_WALK = 8'b0010_0110;

    localparam int MS_NSG  = 0;
    localparam int MS_NSY  = 1;
    localparam int MS_EWG  = 2;
    localparam int MS_EWY  = 3;
    localparam int MS_WALK = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i = 1'b0;
    logic north_green, north_yellow, north_red;
    logic east_green, east_yellow, east_red;
    logic walk_green, walk_red;
    logic [7:0] lamps;

    always #10 clk = ~clk;

    tsc #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .WALK_CYC   (WALK_CYC),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i            (i),
        .NORTH_GREEN  (north_green),
        .NORTH_YELLOW (north_yellow),
        .NORTH_RED    (north_red),
        .EAST_GREEN   (east_green),
        .EAST_YELLOW  (east_yellow),
        .EAST_RED     (east_red),
        .WALK_GREEN   (walk_green),
        .WALK_RED     (walk_red)
    );

    assign lamps = {north_green, north_yellow, north_red,
                    east_green, east_yellow, east_red,
                    walk_green, walk_red};

    typedef struct {
        int lo0; int hi0; int lo1; int hi1; int len; int abort_at;
    } scen_t;

    typedef struct {
        int scen; int edge_n; logic [7:0] exp;
    } chk_t;

    scen_t      scens[8];
    chk_t       chks[$];
    logic [7:0] sb_q[$];
    int         total = 0;
    int         bad = 0;

    int m_st;
    int m_left;
    bit m_req;
    bit m_dir_ew;

    function automatic logic [7:0] lamp_of(int s);
        case (s)
            MS_NSG:  return L_NSG;
            MS_NSY:  return L_NSY;
            MS_EWG:  return L_EWG;
            MS_EWY:  return L_EWY;
            MS_WALK: return L_WALK;
            default: return 8'b0010_0101;
        endcase
    endfunction

    function automatic int phase_len(int s);
        case (s)
            MS_NSG, MS_EWG: return GREEN_CYC;
            MS_NSY, MS_EWY: return YELLOW_CYC;
            default:        return WALK_CYC;
        endcase
    endfunction

    task automatic model_reset();
        m_st     = MS_NSG;
        m_left   = GREEN_CYC;
        m_req    = 1'b0;
        m_dir_ew = 1'b1;
    endtask

    // Phase-remaining down-count model of one rising edge.
    task automatic model_step(input bit in_i);
        int nxt;
        bit last;
        nxt  = m_st;
        last = (m_left == 1);
        if (last) begin
            case (m_st)
                MS_NSG: nxt = MS_NSY;
                MS_NSY: begin
                    if (m_req || in_i) begin nxt = MS_WALK; m_dir_ew = 1'b1; end
                    else nxt = MS_EWG;
                end
                MS_EWG: nxt = MS_EWY;
                MS_EWY: begin
                    if (m_req || in_i) begin nxt = MS_WALK; m_dir_ew = 1'b0; end
                    else nxt = MS_NSG;
                end
                default: nxt = m_dir_ew ? MS_EWG : MS_NSG;
            endcase
        end
        if (nxt == MS_WALK && m_st != MS_WALK) m_req = 1'b0;
        else if (in_i && m_st != MS_WALK)      m_req = 1'b1;
        m_left = last ? phase_len(nxt) : m_left - 1;
        m_st   = nxt;
    endtask

    task automatic check(input string name, input int s, input int n,
                         input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s scen=%0d edge=%0d: lamps=%b expected=%b", name, s, n, act, exp);
        end
    endtask

    task automatic add_chk(input int s, input int n, input logic [7:0] exp);
        chk_t c;
        c.scen = s; c.edge_n = n; c.exp = exp;
        chks.push_back(c);
    endtask

    task automatic run_scen(input int s);
        bit pi;
        reset = 1'b1;
        i = 1'b0;
        @(negedge clk);
        check("reset_lamps", s, 0, lamps, L_NSG);
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        for (int n = 1; n <= scens[s].len; n++) begin
            pi = (n >= scens[s].lo0 && n <= scens[s].hi0) ||
                 (n >= scens[s].lo1 && n <= scens[s].hi1);
            i = pi;
            model_step(pi);
            sb_q.push_back(lamp_of(m_st));
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty scen=%0d edge=%0d: queue size=0 required>0", s, n);
            end else begin
                check("scoreboard", s, n, lamps, sb_q.pop_front());
            end
            foreach (chks[k]) begin
                if (chks[k].scen == s && chks[k].edge_n == n)
                    check("checkpoint", s, n, lamps, chks[k].exp);
            end
            if (n == scens[s].abort_at) begin
                #4 reset = 1'b1;
                #1 check("async_reset", s, n, lamps, L_NSG);
                break;
            end
        end
        i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        //           lo0 hi0 lo1 hi1 len abort
        scens[0] = '{0, -1, 0, -1, 27, 0};   // no requests
        scens[1] = '{6, 6, 22, 22, 39, 0};   // press in NS green, then in EW green
        scens[2] = '{9, 19, 35, 35, 52, 0};  // held through WALK, later press
        scens[3] = '{13, 13, 0, -1, 20, 0};  // press on final NS yellow edge
        scens[4] = '{6, 6, 0, -1, 15, 15};   // reset in the middle of WALK
        scens[5] = '{0, -1, 0, -1, 14, 0};
        scens[6] = '{3, 3, 0, -1, 5, 5};     // reset with a request pending
        scens[7] = '{0, -1, 0, -1, 14, 0};

        add_chk(0, 1, L_NSG);  add_chk(0, 9, L_NSG);  add_chk(0, 10, L_NSY);
        add_chk(0, 12, L_NSY); add_chk(0, 13, L_EWG); add_chk(0, 22, L_EWG);
        add_chk(0, 23, L_EWY); add_chk(0, 25, L_EWY); add_chk(0, 26, L_NSG);

        add_chk(1, 10, L_NSY); add_chk(1, 12, L_NSY); add_chk(1, 13, L_WALK);
        add_chk(1, 18, L_WALK); add_chk(1, 19, L_EWG); add_chk(1, 28, L_EWG);
        add_chk(1, 29, L_EWY); add_chk(1, 31, L_EWY); add_chk(1, 32, L_WALK);
        add_chk(1, 37, L_WALK); add_chk(1, 38, L_NSG);

        add_chk(2, 13, L_WALK); add_chk(2, 19, L_EWG); add_chk(2, 29, L_EWY);
        add_chk(2, 32, L_NSG);  add_chk(2, 42, L_NSY); add_chk(2, 45, L_WALK);
        add_chk(2, 50, L_WALK); add_chk(2, 51, L_EWG);

        add_chk(3, 12, L_NSY); add_chk(3, 13, L_WALK); add_chk(3, 19, L_EWG);

        add_chk(4, 13, L_WALK); add_chk(4, 15, L_WALK);
        add_chk(5, 10, L_NSY);  add_chk(5, 13, L_EWG);
        add_chk(6, 5, L_NSG);
        add_chk(7, 10, L_NSY);  add_chk(7, 13, L_EWG);

        for (int s = 0; s < 8; s++) run_scen(s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
